fb_server: RTL and testbench

- Frame-buffer responder on the pixel-fetch interface of the VGA timing controller.
- Answers row_addr/col_addr/rdn requests with 12-bit pixel data on d_out, which drives the controller's d_in.
- Stores a 160x120 logical frame, upscaled 4x to 640x480.
- Game logic writes single pixels through a valid/ready port, or issues a full-screen clear.

---
 rtl/fb_pkg.sv | 38 +++
 rtl/fb_ram.sv | 38 +++
 rtl/fb_server.sv | 184 ++++++++++++++++++
 tb/tb_fb_server.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the fb_server frame buffer.
// Optional build macro: FB_DBLBUF_EN (two display pages with vblank-synchronous swap).
package fb_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_WORDS = FB_W * FB_H;
  localparam int unsigned SCALE_SH = 2;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned CNT_W    = 15;

`ifdef FB_DBLBUF_EN
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned RAM_DEPTH = 2 * FB_WORDS;
`else
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned RAM_DEPTH = FB_WORDS;
`endif

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef logic [0:0] fb_state_t;
  localparam fb_state_t IDLE  = 1'b0;
  localparam fb_state_t CLEAR = 1'b1;

  // Linear cell index y*160 + x, built from shifts so no multiplier is inferred.
  function automatic fb_addr_t cell_addr(input logic [9:0] x, input logic [9:0] y);
    return (fb_addr_t'(y) << 7) + (fb_addr_t'(y) << 5) + fb_addr_t'(x);
  endfunction

  // Base address of a page within the RAM.
  function automatic fb_addr_t page_base(input logic page);
    return page ? fb_addr_t'(FB_WORDS) : '0;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read returning old data on collision.
// Read data register is zeroed when the read is disabled so it can drive the pixel bus directly.
module fb_ram #(
  parameter int unsigned DEPTH = 19200,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port with resettable output register; blanked reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/fb_server.sv
// Frame-buffer responder for the VGA timing controller: 160x120 cells upscaled 4x,
// single-pixel write port, full-screen clear engine.
// Optional build macro: FB_DBLBUF_EN (back-page writes, display-page swap at vblank).
module fb_server
  import fb_pkg::*;
(
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [9:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_out,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        clr_req,
  input  logic [11:0] clr_color,
  output logic        busy,
  output logic        vblank,
  input  logic        swap_req,
  output logic        swap_done
);

  fb_state_t        state, state_nxt;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
  pixel_t           clr_pix, clr_pix_nxt;

  logic [9:0] look_col, cell_x, cell_y;
  logic       in_blank, rd_en;
  fb_addr_t   rd_addr;
  fb_addr_t   disp_base, back_base;

  logic       hs, wr_in_range;
  logic       wr_pend;
  fb_addr_t   wr_addr_q;
  pixel_t     wr_data_q;

  logic       ram_we;
  fb_addr_t   ram_waddr;
  pixel_t     ram_wdata;

  // Read address: look one column ahead so the pixel lands on its own column after the fetch delay.
  always_comb begin
    look_col = col_addr + 10'd1;
    cell_x   = look_col >> SCALE_SH;
    cell_y   = row_addr >> SCALE_SH;
    in_blank = (row_addr >= 10'(V_ACTIVE));
    rd_en    = !rdn && !in_blank && (cell_x < 10'(FB_W));
    rd_addr  = cell_addr(cell_x, cell_y) + disp_base;
  end

  // State register with registered status outputs decoded from the next state.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_pix  <= '0;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_pix  <= clr_pix_nxt;
      busy     <= (state_nxt == CLEAR);
      wr_ready <= (state_nxt == IDLE);
    end
  end

  // Next-state logic: clear sweeps every cell once, one word per cycle.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_pix_nxt = clr_pix;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          clr_pix_nxt = clr_color;
        end
      end
      CLEAR: begin
        if (clr_cnt == CNT_W'(FB_WORDS - 1)) begin
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs          = wr_valid && wr_ready;
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

  // Write pipeline: register the accepted request, commit it to RAM on the next edge.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_pend <= hs && wr_in_range;
      if (hs) begin
        wr_addr_q <= cell_addr(10'(wr_x), 10'(wr_y)) + back_base;
        wr_data_q <= wr_color;
      end
    end
  end

  // RAM write arbitration: the clear owns the port; a write accepted alongside clr_req is superseded.
  always_comb begin
    ram_we    = wr_pend;
    ram_waddr = wr_addr_q;
    ram_wdata = wr_data_q;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = fb_addr_t'(clr_cnt) + back_base;
      ram_wdata = clr_pix;
    end
  end

  // Vertical blanking flag.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      vblank <= 1'b1;
    end else begin
      vblank <= in_blank;
    end
  end

`ifdef FB_DBLBUF_EN
  logic disp_page, swap_pend, swap_fire;

  assign swap_fire = swap_pend && in_blank && !vblank;
  assign disp_base = page_base(disp_page);
  assign back_base = page_base(!disp_page);

  // Page swap: a pending request toggles the display page on the vblank rising edge.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      disp_page <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_fire;
      swap_pend <= swap_req || (swap_pend && !swap_fire);
      if (swap_fire) begin
        disp_page <= !disp_page;
      end
    end
  end
`else
  assign disp_base = '0;
  assign back_base = '0;

  // Single page: swap requests have no effect and swap_done stays low.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_req & 1'b0;
    end
  end
`endif

  fb_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (ADDR_W),
    .DW    (PIX_W)
  ) u_ram (
    .clk     (vga_clk),
    .rst_n   (clrn),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (d_out),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata)
  );

endmodule

// File: tb/tb_fb_server.sv
// Self-checking bench for fb_server (single-page build).
`timescale 1ns/1ps
module tb_fb_server;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic [9:0]  row_addr, col_addr;
  logic        rdn;
  logic [11:0] d_out;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_color;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        busy, vblank;
  logic        swap_req, swap_done;

  fb_server dut (
    .vga_clk   (vga_clk),
    .clrn      (clrn),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .rdn       (rdn),
    .d_out     (d_out),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .busy      (busy),
    .vblank    (vblank),
    .swap_req  (swap_req),
    .swap_done (swap_done)
  );

  always #20 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb_q[$];
  int          tag_q[$];
  logic [11:0] model[19200];

  typedef struct {
    logic [9:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock: sample d_out 1ns after the edge against the oldest expected read, return at negedge.
  task automatic tick();
    logic [11:0] e;
    int          t;
    @(posedge vga_clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (d_out !== e) begin
        errors++;
        $display("FAIL rd%0d d_out=%h exp=%h", t, d_out, e);
      end
    end
    @(negedge vga_clk);
  endtask

  function automatic logic [11:0] model_px(input int r, input int c, input bit n);
    int x, y;
    x = ((c + 1) % 1024) / 4;
    y = r / 4;
    if (n || r >= 480 || x >= 160) return 12'h000;
    return model[y * 160 + x];
  endfunction

  task automatic rd(input int r, input int c, input logic n, input logic [11:0] e, input int tg);
    row_addr = 10'(r);
    col_addr = 10'(c);
    rdn      = n;
    sb_q.push_back(e);
    tag_q.push_back(tg);
    tick();
  endtask

  task automatic wr(input int x, input int y, input logic [11:0] col);
    int n = 0;
    wr_x     = 8'(x);
    wr_y     = 7'(y);
    wr_color = col;
    wr_valid = 1'b1;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    check("wr_ready_hs", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    if (x < 160 && y < 120) model[y * 160 + x] = col;
  endtask

  initial begin
    int n, nrdy, tg;
    vecs[0]  = '{10'd12,  10'd19,   1'b0, 12'hF00};
    vecs[1]  = '{10'd12,  10'd23,   1'b0, 12'h0F0};
    vecs[2]  = '{10'd12,  10'd18,   1'b0, 12'h0A5};
    vecs[3]  = '{10'd0,   10'd1023, 1'b0, 12'h00F};
    vecs[4]  = '{10'd480, 10'd1023, 1'b0, 12'h000};
    vecs[5]  = '{10'd0,   10'd1023, 1'b1, 12'h000};
    vecs[6]  = '{10'd0,   10'd639,  1'b0, 12'h000};
    vecs[7]  = '{10'd0,   10'd638,  1'b0, 12'h0A5};
    vecs[8]  = '{10'd479, 10'd635,  1'b0, 12'hABC};
    vecs[9]  = '{10'd4,   10'd1023, 1'b0, 12'h0A5};
    vecs[10] = '{10'd0,   10'd3,    1'b0, 12'h0A5};
    vecs[11] = '{10'd700, 10'd0,    1'b0, 12'h000};
    vecs[12] = '{10'd12,  10'd20,   1'b0, 12'hF00};
    vecs[13] = '{10'd15,  10'd16,   1'b0, 12'h0A5};

    clrn = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_req = 1'b0; clr_color = '0; swap_req = 1'b0;

    // Reset state
    repeat (2) @(negedge vga_clk);
    check("rst_d_out", 32'(d_out), 32'h0);
    check("rst_vblank", 32'(vblank), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    clrn = 1'b1;
    tick();

    // vblank tracking; swap requests have no effect in the single-page build
    row_addr = 10'd480; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("vblank_hi", 32'(vblank), 32'd1);
    check("swap_done_a", 32'(swap_done), 32'd0);
    row_addr = 10'd0;
    tick();
    check("vblank_lo", 32'(vblank), 32'd0);
    row_addr = 10'd480;
    tick();
    check("vblank_rise", 32'(vblank), 32'd1);
    check("swap_done_b", 32'(swap_done), 32'd0);
    row_addr = 10'd0;

    // Full clear with a mid-clear clr_req that must be ignored
    clr_color = 12'h0A5; clr_req = 1'b1;
    check("clr_accept_ready", 32'(wr_ready), 32'd1);
    tick();
    clr_req = 1'b0; clr_color = 12'h777;
    n = 0; nrdy = 0;
    while (busy && n < 20000) begin
      if (wr_ready) nrdy++;
      clr_req = (n == 5000);
      tick();
      n++;
    end
    clr_req = 1'b0;
    check("busy_len", 32'(n), 32'd19200);
    check("ready_low_in_clear", 32'(nrdy), 32'd0);
    check("ready_after_clear", 32'(wr_ready), 32'd1);
    tick();
    check("no_restart", 32'(busy), 32'd0);
    for (int i = 0; i < 19200; i++) model[i] = 12'h0A5;

    // Every cell reads back the fill colour
    tg = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        rd(y * 4, (x == 0) ? 1023 : x * 4 - 1, 1'b0, model_px(y * 4, (x == 0) ? 1023 : x * 4 - 1, 1'b0), tg);
        tg++;
      end
    end
    rdn = 1'b1;
    tick();

    // Pixel writes, including two out-of-range ones that must be dropped
    wr(5, 3, 12'hF00);
    wr(6, 3, 12'h0F0);
    wr(0, 0, 12'h00F);
    wr(159, 119, 12'hABC);
    wr(160, 0, 12'hFFF);
    wr(0, 120, 12'hFFF);
    tick();

    // Read-path vector table
    for (int i = 0; i < 14; i++) begin
      rd(int'(vecs[i].row), int'(vecs[i].col), vecs[i].rdn, vecs[i].exp, 100000 + i);
    end
    rdn = 1'b1;
    tick();

    // Write and clear in the same cycle, then reset at clear cycle 100
    wr_valid = 1'b1; wr_x = 8'd50; wr_y = 7'd0; wr_color = 12'hEEE;
    clr_req = 1'b1; clr_color = 12'h3C3;
    check("wr_clr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    check("abort_busy_start", 32'(busy), 32'd1);
    check("abort_ready_low", 32'(wr_ready), 32'd0);
    repeat (100) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    clrn = 1'b0;
    #1;
    check("abort_busy_rst", 32'(busy), 32'd0);
    check("abort_ready_rst", 32'(wr_ready), 32'd1);
    tick();
    clrn = 1'b1;
    tick();
    check("abort_busy_rel", 32'(busy), 32'd0);
    check("abort_ready_rel", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 100; i++) model[i] = 12'h3C3;
    for (int i = 0; i < 400; i++) begin
      rd((i / 160) * 4, ((i % 160) == 0) ? 1023 : (i % 160) * 4 - 1, 1'b0,
         model_px((i / 160) * 4, ((i % 160) == 0) ? 1023 : (i % 160) * 4 - 1, 1'b0), 200000 + i);
    end
    rd(12, 19, 1'b0, model_px(12, 19, 1'b0), 300000);
    rd(12, 23, 1'b0, model_px(12, 23, 1'b0), 300001);
    rd(476, 635, 1'b0, model_px(476, 635, 1'b0), 300002);
    rdn = 1'b1;
    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
